// File: rtl/div_16b_seq_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The requester drives start/A/B; the divider returns busy/done and the results.
interface div_16b_seq_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, A, B,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, A, B,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_16b_seq.sv
// Iterative unsigned shift-and-subtract divider retiring one quotient bit per cycle.
// A zero divisor skips the iterations and completes in one cycle with a flag.
module div_16b_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    div_16b_seq_if.slave bus
);
    localparam int unsigned     CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH:0]  ONE  = (WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] r_reg;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] r_n;

    // The partial remainder is always below the divisor between iterations, so its
    // top bit is zero and only the shifted 17-bit value R' needs the extra bit.
    always_comb begin
        r_sh = {r_reg, q_reg[WIDTH-1]};
        q_sh = {q_reg[WIDTH-2:0], 1'b0};
        diff = r_sh + ~{1'b0, d_reg} + ONE;
        if (!diff[WIDTH]) begin
            r_n = diff[WIDTH-1:0];
            q_n = {q_reg[WIDTH-2:0], 1'b1};
        end else begin
            r_n = r_sh[WIDTH-1:0];
            q_n = q_sh;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            q_reg           <= '0;
            d_reg           <= '0;
            r_reg           <= '0;
            cnt             <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        q_reg <= bus.A;
                        d_reg <= bus.B;
                        r_reg <= '0;
                        cnt   <= '0;
                        if (bus.B != '0) begin
                            state    <= RUN;
                            bus.busy <= 1'b1;
                        end else begin
                            state           <= DONE;
                            bus.done        <= 1'b1;
                            bus.quotient    <= '1;
                            bus.remainder   <= bus.A;
                            bus.div_by_zero <= 1'b1;
                        end
                    end else if (state == DONE) begin
                        state <= IDLE;
                    end
                end

                RUN: begin
                    q_reg <= q_n;
                    r_reg <= r_n;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state           <= DONE;
                        bus.busy        <= 1'b0;
                        bus.done        <= 1'b1;
                        bus.quotient    <= q_n;
                        bus.remainder   <= r_n;
                        bus.div_by_zero <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_16b_seq.sv
// Directed and randomised checks of div_16b_seq: latency, results, zero divisor,
// ignored/back-to-back starts and mid-run reset.
module tb_div_16b_seq;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    div_16b_seq_if #(.WIDTH(16)) bus ();

    div_16b_seq #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one edge, then count negedges until done (bounded at 20).
    task automatic run_div(input logic [15:0] a, input logic [15:0] b, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = 16'h0;
        bus.B     = 16'h0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = 16'h0;
        bus.B     = 16'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: busy/done/dbz=%b required 000", {bus.busy, bus.done, bus.div_by_zero});
        end
        n_checks++;
        if (bus.quotient !== 16'h0 || bus.remainder !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_results: q=%h r=%h required 0000 0000", bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 16'd100;
        bus.B     = 16'd7;
        @(posedge clk);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            n_checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_busy cycle %0d: busy=%b done=%b required 1 0", c, bus.busy, bus.done);
            end
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.quotient !== 16'd14 ||
            bus.remainder !== 16'd2 || bus.div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: done=%b busy=%b q=%0d r=%0d dbz=%b required 1 0 14 2 0",
                     bus.done, bus.busy, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_after: done=%b busy=%b required 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_boundaries();
        logic [15:0] va [5] = '{16'hFFFF, 16'd5, 16'hFFFF, 16'h8000, 16'd1};
        logic [15:0] vb [5] = '{16'd1,    16'd9, 16'hFFFF, 16'h0003, 16'd1};
        logic [15:0] vq [5] = '{16'hFFFF, 16'd0, 16'd1,    16'h2AAA, 16'd1};
        logic [15:0] vr [5] = '{16'd0,    16'd5, 16'd0,    16'd2,    16'd0};
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_div(va[i], vb[i], lat);
            n_checks++;
            if (lat != 17 || bus.quotient !== vq[i] || bus.remainder !== vr[i] || bus.div_by_zero !== 1'b0) begin
                n_fail++;
                $display("FAIL boundary %h/%h: lat=%0d q=%h r=%h dbz=%b required 17 %h %h 0",
                         va[i], vb[i], lat, bus.quotient, bus.remainder, bus.div_by_zero, vq[i], vr[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        run_div(16'd1234, 16'd0, lat);
        n_checks++;
        if (lat != 1 || bus.busy !== 1'b0 || bus.div_by_zero !== 1'b1 ||
            bus.quotient !== 16'hFFFF || bus.remainder !== 16'd1234) begin
            n_fail++;
            $display("FAIL div_zero: lat=%0d busy=%b dbz=%b q=%h r=%0d required 1 0 1 ffff 1234",
                     lat, bus.busy, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.quotient !== 16'hFFFF || bus.div_by_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL div_zero_hold: done=%b busy=%b q=%h dbz=%b required 0 0 ffff 1",
                     bus.done, bus.busy, bus.quotient, bus.div_by_zero);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 16'd1000;
        bus.B     = 16'd10;
        @(posedge clk);
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            bus.start = (c == 5);
            bus.A     = 16'd9;
            bus.B     = 16'd3;
        end
        // Now in cycle 17 with start raised for the follow-up divide.
        n_checks++;
        if (bus.done !== 1'b1 || bus.quotient !== 16'd100 || bus.remainder !== 16'd0) begin
            n_fail++;
            $display("FAIL b2b_first: done=%b q=%0d r=%0d required 1 100 0", bus.done, bus.quotient, bus.remainder);
        end
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.quotient !== 16'd100) begin
            n_fail++;
            $display("FAIL b2b_accept: done=%b busy=%b q=%0d required 0 1 100", bus.done, bus.busy, bus.quotient);
        end
        repeat (16) @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b1 || bus.quotient !== 16'd3 || bus.remainder !== 16'd0) begin
            n_fail++;
            $display("FAIL b2b_second: done=%b q=%0d r=%0d required 1 3 0", bus.done, bus.quotient, bus.remainder);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 16'd50000;
        bus.B     = 16'd3;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.quotient !== 16'h0 || bus.remainder !== 16'h0) begin
            n_fail++;
            $display("FAIL midrun_reset: busy/done/dbz=%b q=%h r=%h required 000 0000 0000",
                     {bus.busy, bus.done, bus.div_by_zero}, bus.quotient, bus.remainder);
        end
        seen_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
        end
        n_checks++;
        if (seen_done != 0) begin
            n_fail++;
            $display("FAIL midrun_quiet: active cycles=%0d required 0", seen_done);
        end
        run_div(16'd50000, 16'd3, lat);
        n_checks++;
        if (lat != 17 || bus.quotient !== 16'd16666 || bus.remainder !== 16'd2) begin
            n_fail++;
            $display("FAIL midrun_fresh: lat=%0d q=%0d r=%0d required 17 16666 2", lat, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] eq;
        logic [15:0] er;
        int          elat;
        int          lat;
        for (int i = 0; i < 2000; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 16'h0;
                1, 2:    b = 16'($urandom_range(1, 255));
                default: b = 16'($urandom);
            endcase
            if (b == 16'h0) begin
                eq = 16'hFFFF;
                er = a;
                elat = 1;
            end else begin
                eq = a / b;
                er = a % b;
                elat = 17;
            end
            run_div(a, b, lat);
            n_checks++;
            if (lat != elat || bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== (b == 16'h0)) begin
                n_fail++;
                $display("FAIL random %h/%h: lat=%0d q=%h r=%h dbz=%b required %0d %h %h %b",
                         a, b, lat, bus.quotient, bus.remainder, bus.div_by_zero, elat, eq, er, (b == 16'h0));
            end
            @(negedge clk);
            n_checks++;
            if (bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL random_pulse %h/%h: done=%b required 0", a, b, bus.done);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
